control_temporizado: RTL



---
 rtl/control_temporizado.sv | 133 +++++++++++++
 1 files changed

// File: rtl/control_temporizado.sv
`default_nettype none
// ============================================================================
// Module   : control_temporizado
// Purpose  : Timed activation controller. Qualifies a request R over T_MIN
//            samples, opens an a_e window of T_ON cycles, pulses c once, and
//            waits for R to be released before re-arming.
//            Optional: `CONTROL_TEMPORIZADO_RETRIGGER_EN lets a rising edge of
//            R during ACTIVE restart the window.
// Revision : 1.0 - initial release
// ============================================================================

module control_temporizado #(
    parameter int W     = 4,
    parameter int T_MIN = 2,
    parameter int T_ON  = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         R,
    output logic         a_e,
    output logic         c,
    output logic [W-1:0] cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_ACTIVE   = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_REL = 3'd4
    } state_t;

    // Terminal values compared against the current count (cnt+1 == T_MIN
    // is tested as cnt == T_MIN-1 so the sum can never need an extra bit).
    localparam logic [W-1:0] c_T_MIN_M1 = W'(T_MIN - 1);
    localparam logic [W-1:0] c_T_ON_M1  = W'(T_ON - 1);
    localparam logic [W-1:0] c_ONE      = W'(1);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;

`ifdef CONTROL_TEMPORIZADO_RETRIGGER_EN
    logic           r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= R;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (R) begin
                    if (T_MIN == 1) begin
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_ARM;
                        cnt_d   = c_ONE;
                    end
                end
            end
            S_ARM: begin
                if (!R) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_T_MIN_M1) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_ACTIVE: begin
`ifdef CONTROL_TEMPORIZADO_RETRIGGER_EN
                // A fresh request edge restarts the window, even on its last cycle.
                if (R && !r_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_T_ON_M1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
`else
                if (cnt_q == c_T_ON_M1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
`endif
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = R ? S_WAIT_REL : S_IDLE;
            end
            S_WAIT_REL: begin
                cnt_d = '0;
                if (!R) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign a_e = (state_q == S_ACTIVE);
    assign c   = (state_q == S_DONE);
    assign cnt = cnt_q;

endmodule

`default_nettype wire
